// File: rtl/muxn_pipe.sv
// muxn_pipe: N:1 mux with registered output and a valid/ready skid buffer
module muxn_pipe #(
  parameter int M = 32,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*M-1:0] d,
  input  logic [SW-1:0]  sel,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic [M-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err_oor
);
  logic [M-1:0] ch [2**SW];
  logic [M-1:0] skid_data;
  logic         skid_valid;
  logic         it;
  logic         ot;
  genvar i;
  // select codes past N map to zero-filled slots, so out-of-range reads yield 0
  for (i = 0; i < 2**SW; i++) begin : g_ch
    if (i < N) begin : g_in
      assign ch[i] = d[i*M +: M];
    end else begin : g_z
      assign ch[i] = '0;
    end
  end
  assign in_ready = ~skid_valid;
  assign it = in_valid & ~skid_valid & ~flush;
  assign ot = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      err_oor    <= 1'b0;
    end else begin
      out_valid  <= ~flush & (it | skid_valid | (out_valid & ~ot));
      skid_valid <= ~flush & (skid_valid ? ~ot : it & out_valid & ~ot);
      if (it & (~out_valid | ot)) out_data <= ch[sel];
      else if (skid_valid & ot & ~flush) out_data <= skid_data;
      if (it & out_valid & ~ot) skid_data <= ch[sel];
      err_oor <= err_oor | (it & (32'(sel) >= N));
    end
  end
endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: directed and random checks against a FIFO reference model
module tb_muxn_pipe;
  logic         clk = 0;
  logic         rst = 1;
  logic [127:0] d = '0;
  logic [1:0]   sel = '0;
  logic         iv = 0, flush = 0, ordy = 0;
  logic         ir, ov, err;
  logic [31:0]  od;
  logic [39:0]  d5 = '0;
  logic [2:0]   sel5 = '0;
  logic         iv5 = 0, ir5, ov5, err5;
  logic [7:0]   od5;
  int           checks = 0, passes = 0;
  logic         chk_en = 0;
  logic [31:0]  q [$];
  logic [31:0]  mdata = '0;
  logic [31:0]  vals [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

  muxn_pipe #(.M(32), .N(4)) u4 (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .in_valid(iv), .in_ready(ir),
    .flush(flush), .out_data(od), .out_valid(ov), .out_ready(ordy), .err_oor(err)
  );
  muxn_pipe #(.M(8), .N(5)) u5 (
    .clk(clk), .rst(rst), .d(d5), .sel(sel5), .in_valid(iv5), .in_ready(ir5),
    .flush(flush), .out_data(od5), .out_valid(ov5), .out_ready(ordy), .err_oor(err5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s actual=%h expected=%h", n, a, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: an at-most-two-deep queue of accepted beats; head is what is shown
  always @(posedge clk) begin
    logic t_in, t_out;
    if (rst) begin
      q.delete();
      mdata = '0;
    end else begin
      t_out = q.size() > 0 && ordy;
      t_in  = iv && q.size() < 2 && !flush;
      if (t_out) void'(q.pop_front());
      if (t_in) q.push_back(d[32*sel +: 32]);
      if (flush) q.delete();
      if (!flush && q.size() > 0) mdata = q[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model out_valid", 64'(ov), 64'(q.size() > 0));
      chk("model in_ready", 64'(ir), 64'(q.size() < 2));
      chk("model out_data", 64'(od), 64'(mdata));
      chk("model err_oor", 64'(err), 64'd0);
    end
  end

  initial begin
    step();
    step();
    rst = 0;
    chk_en = 1;
    chk("reset out_valid", 64'(ov), 64'd0);
    chk("reset out_data", 64'(od), 64'd0);
    chk("reset in_ready", 64'(ir), 64'd1);
    chk("reset err_oor", 64'(err), 64'd0);
    // single beat
    d[64 +: 32] = 32'hDEAD_BEEF;
    sel = 2; iv = 1; ordy = 1;
    step();
    iv = 0;
    chk("t1 out_valid", 64'(ov), 64'd1);
    chk("t1 out_data", 64'(od), 64'hDEAD_BEEF);
    chk("t1 in_ready", 64'(ir), 64'd1);
    step();
    chk("t1 drained", 64'(ov), 64'd0);
    // back-to-back stream
    for (int k = 0; k < 4; k++) d[32*k +: 32] = vals[k];
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); iv = 1;
      step();
      chk("t2 out_data", 64'(od), 64'(vals[k]));
      chk("t2 in_ready", 64'(ir), 64'd1);
    end
    iv = 0;
    step();
    // fill to FULL, then drain
    ordy = 0; iv = 1; sel = 0;
    step();
    sel = 1;
    step();
    iv = 0;
    chk("t3 full in_ready", 64'(ir), 64'd0);
    chk("t3 full out_data", 64'(od), 64'h1111_0000);
    ordy = 1;
    step();
    chk("t3 second out_data", 64'(od), 64'h2222_0001);
    chk("t3 second in_ready", 64'(ir), 64'd1);
    step();
    chk("t3 empty", 64'(ov), 64'd0);
    // flush while FULL with a beat offered
    ordy = 0; iv = 1; sel = 0;
    step();
    sel = 1;
    step();
    flush = 1; sel = 2;
    step();
    flush = 0; iv = 0;
    chk("t5 out_valid", 64'(ov), 64'd0);
    chk("t5 in_ready", 64'(ir), 64'd1);
    chk("t5 out_data held", 64'(od), 64'h1111_0000);
    ordy = 1;
    step();
    chk("t5 not captured", 64'(ov), 64'd0);
    // N=5 out-of-range select
    iv5 = 1; sel5 = 7; d5 = 40'hFF_FFFF_FFFF;
    step();
    iv5 = 0;
    chk("t4 oor data", 64'(od5), 64'd0);
    chk("t4 oor err", 64'(err5), 64'd1);
    chk("t4 oor valid", 64'(ov5), 64'd1);
    iv5 = 1; sel5 = 4; d5 = 40'h5A_0102_0304;
    step();
    iv5 = 0;
    chk("t4 ch4 data", 64'(od5), 64'h5A);
    chk("t4 err sticky", 64'(err5), 64'd1);
    iv5 = 1; sel5 = 1;
    step();
    iv5 = 0;
    chk("t4 ch1 data", 64'(od5), 64'h03);
    step();
    chk("t4 err still", 64'(err5), 64'd1);
    // reset mid-stream in ONE
    ordy = 0; iv = 1; sel = 3;
    step();
    chk("t6 in ONE", 64'(ov), 64'd1);
    rst = 1; iv = 0;
    step();
    rst = 0;
    chk("t6 rst out_valid", 64'(ov), 64'd0);
    chk("t6 rst out_data", 64'(od), 64'd0);
    chk("t6 rst in_ready", 64'(ir), 64'd1);
    chk("t6 rst err5", 64'(err5), 64'd0);
    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      iv = 1'($urandom);
      ordy = 1'($urandom);
      sel = 2'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    iv = 0; flush = 0;
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
